masked_sbox_bram_ctrl: RTL and testbench

MASKED_SBOX_BRAM_CTRL -- requirements
Module: masked_sbox_bram_ctrl

---
 rtl/masked_sbox_bram_ctrl.sv | 93 +++++++++
 tb/tb_masked_sbox_bram_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_bram_ctrl.sv
// masked_sbox_bram_ctrl: two-cycle dual-port BRAM lookup controller with output backpressure.
// Define MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN to add a round-robin arbitrated key-schedule requester.
module masked_sbox_bram_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [ADDR_W-1:0] d_addra,
  input  logic [ADDR_W-1:0] d_addrb,
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
  input  logic              k_valid,
  output logic              k_ready,
  input  logic [ADDR_W-1:0] k_addra,
  input  logic [ADDR_W-1:0] k_addrb,
`endif
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_en,
  output logic              bram_rst,
  input  logic [DATA_W-1:0] bram_doa,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_doa,
  output logic [DATA_W-1:0] out_dob,
  output logic              out_tag
);
  logic v1_q, v1_d, v2_q, v2_d, d_go, k_go;
  logic [ADDR_W-1:0] a_q, a_d, b_q, b_d;
  assign bram_en   = !(out_valid && !out_ready);
  assign bram_rst  = !rst;
  assign out_valid = v2_q;
  assign out_doa   = bram_doa;
  assign out_dob   = bram_dob;
  assign d_go      = d_valid && d_ready;
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
  logic lg_q, lg_d, t1_q, t1_d, t2_q, t2_d;
  // lg_q records the last winner: 0 = data path, 1 = key schedule
  assign d_ready = bram_en && rst && (!k_valid || lg_q);
  assign k_ready = bram_en && rst && (!d_valid || !lg_q);
  assign k_go    = k_valid && k_ready;
  assign out_tag = t2_q;
  always_comb begin
    bram_addra = k_go ? k_addra : d_go ? d_addra : a_q;
    bram_addrb = k_go ? k_addrb : d_go ? d_addrb : b_q;
    lg_d       = k_go ? 1'b1 : d_go ? 1'b0 : lg_q;
    t1_d       = bram_en ? k_go : t1_q;
    t2_d       = bram_en ? t1_q : t2_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lg_q <= 1'b0;
      t1_q <= 1'b0;
      t2_q <= 1'b0;
    end else begin
      lg_q <= lg_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
    end
  end
`else
  assign d_ready = bram_en && rst;
  assign k_go    = 1'b0;
  assign out_tag = 1'b0;
  always_comb begin
    bram_addra = d_go ? d_addra : a_q;
    bram_addrb = d_go ? d_addrb : b_q;
  end
`endif
  // stage 1 = address registered in BRAM, stage 2 = data in BRAM output register
  always_comb begin
    v1_d = bram_en ? (d_go || k_go) : v1_q;
    v2_d = bram_en ? v1_q : v2_q;
    a_d  = bram_addra;
    b_d  = bram_addrb;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end
endmodule

// File: tb/tb_masked_sbox_bram_ctrl.sv
// tb_masked_sbox_bram_ctrl: scoreboard bench with a two-stage BRAM model for masked_sbox_bram_ctrl.
module tb_masked_sbox_bram_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
  logic clk = 1'b0, rst = 1'b0, d_valid = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] d_addra = '0, d_addrb = '0;
  logic d_ready, bram_en, bram_rst, out_valid, out_tag;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [AW-1:0] ra = '0, rb = '0;
  logic [DW-1:0] bram_doa = '0, bram_dob = '0, out_doa, out_dob;
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
  logic k_valid = 1'b0, k_ready;
  logic [AW-1:0] k_addra = '0, k_addrb = '0;
`endif
  int n_cmp = 0, n_bad = 0, run = 0, max_run = 0, n_rx = 0, n0 = 0;
  logic [2*DW:0] q[$];

  masked_sbox_bram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready), .d_addra(d_addra), .d_addrb(d_addrb),
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
    .k_valid(k_valid), .k_ready(k_ready), .k_addra(k_addra), .k_addrb(k_addrb),
`endif
    .bram_addra(bram_addra), .bram_addrb(bram_addrb), .bram_en(bram_en), .bram_rst(bram_rst),
    .bram_doa(bram_doa), .bram_dob(bram_dob),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_doa(out_doa), .out_dob(out_dob), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // BRAM contents
  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (lo * 8'd29) ^ 8'hA5;
  endfunction

  // dual-port BRAM: address register then output register, both gated by bram_en
  always @(posedge clk) begin
    if (bram_en) begin
      ra <= bram_addra;
      rb <= bram_addrb;
    end
    if (bram_rst) begin
      bram_doa <= '0;
      bram_dob <= '0;
    end else if (bram_en) begin
      bram_doa <= f(ra);
      bram_dob <= f(rb);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, act, exp);
    end
  endtask

  task automatic wait_acc();
    logic r;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = d_ready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL accept_timeout: got no d_ready want d_ready within 50 cycles");
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [AW-1:0] b);
    d_valid = 1'b1;
    d_addra = a;
    d_addrb = b;
    wait_acc();
  endtask

  // expected results are queued when a request is seen accepted
  always @(negedge clk) begin
    if (d_valid && d_ready) q.push_back({1'b0, f(d_addra), f(d_addrb)});
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
    if (k_valid && k_ready) q.push_back({1'b1, f(k_addra), f(k_addrb)});
`endif
  end

  initial forever begin
    @(negedge rst);
    q.delete();
  end

  initial forever begin
    @(negedge clk);
    run = out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (out_valid && out_ready) begin
      n_rx++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got tag=%0d doa=0x%0h dob=0x%0h want no result", out_tag, out_doa, out_dob);
      end else begin
        chk("result", {15'd0, out_tag, out_doa, out_dob}, {15'd0, q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_bram_en", bram_en, 1);
    chk("rst_bram_rst", bram_rst, 1);
    chk("rst_addra", bram_addra, 0);
    chk("rst_addrb", bram_addrb, 0);
    chk("rst_out_tag", out_tag, 0);
    // single lookup, offered on the first edge after release
    @(posedge clk);
    #2;
    rst = 1'b1;
    d_valid = 1'b1;
    d_addra = 10'h000;
    d_addrb = 10'h001;
    @(negedge clk);
    chk("first_accept_ready", d_ready, 1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    chk("lat_doa", out_doa, f(10'h000));
    chk("lat_dob", out_dob, f(10'h001));
    @(negedge clk);
    chk("lat_cycle3", out_valid, 0);
    @(posedge clk);
    #1;
    // streaming
    max_run = 0;
    for (int i = 0; i < 16; i++) send(AW'(i), AW'(15 - i));
    d_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_run", max_run, 16);
    // backpressure with two lookups in flight
    n0 = n_rx;
    send(10'h020, 10'h021);
    send(10'h022, 10'h023);
    out_ready = 1'b0;
    d_addra = 10'h024;
    d_addrb = 10'h025;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_en", bram_en, 0);
      chk("stall_ready", d_ready, 0);
      chk("stall_doa", out_doa, f(10'h020));
      chk("stall_dob", out_dob, f(10'h021));
      chk("stall_tag", out_tag, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_acc();
    d_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_count", n_rx - n0, 3);
    // reset with two lookups in flight
    send(10'h028, 10'h029);
    send(10'h02A, 10'h02B);
    d_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bram_en", bram_en, 1);
    chk("midrst_addra", bram_addra, 0);
    n0 = n_rx;
    repeat (2) @(posedge clk);
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_stale", n_rx - n0, 0);
`ifdef MASKED_SBOX_BRAM_CTRL_KEY_PORT_EN
    // both requesters held: K first after reset, then alternating
    d_valid = 1'b1;
    d_addra = 10'h050;
    d_addrb = 10'h051;
    k_valid = 1'b1;
    k_addra = 10'h060;
    k_addrb = 10'h061;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arb_k_ready", k_ready, (i % 2 == 0) ? 1 : 0);
      chk("arb_d_ready", d_ready, (i % 2 == 1) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    d_valid = 1'b0;
    k_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`endif
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
